// File: rtl/f_pc_gen.sv
// Fetch-stage PC generator: holds the fetch PC, resolves the next PC from D-stage
// control flow, buffers redirects that arrive during a stall, and flags illegal fetches.
module f_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] PC_D,
    input  logic        br_take,
    input  logic [15:0] br_imm,
    input  logic        j_en,
    input  logic [25:0] j_index,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    output logic [31:0] PC_F,
    output logic        clear_F,
    output logic        fetch_fault,
    output logic [7:0]  fault_cnt
);

    // Computed one bit wider so a window ending at 2^32 cannot wrap.
    localparam logic [32:0] PcLimit = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic [7:0]  fault_cnt_q, fault_cnt_d;

    logic [31:0] pcd_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] redir_target;
    logic        redir;
    logic        illegal;

    // Redirect target, jr > j > br.
    always_comb begin
        pcd_plus4    = PC_D + 32'd4;
        br_target    = pcd_plus4 + {{14{br_imm[15]}}, br_imm, 2'b00};
        j_target     = {pcd_plus4[31:28], j_index, 2'b00};
        redir        = jr_en | j_en | br_take;
        redir_target = br_target;
        if (jr_en) begin
            redir_target = jr_target;
        end else if (j_en) begin
            redir_target = j_target;
        end
    end

    always_comb begin
        illegal = (pc_q[1:0] != 2'b00)
                | ({1'b0, pc_q} < {1'b0, RESET_PC})
                | ({1'b0, pc_q} >= PcLimit);
    end

    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        fetch_fault_d = fetch_fault_q;
        fault_cnt_d   = fault_cnt_q;

        if (stall) begin
            // Newest redirect seen during the stall wins.
            if (redir) begin
                pend_valid_d  = 1'b1;
                pend_target_d = redir_target;
            end
        end else begin
            pend_valid_d = 1'b0;
            if (redir) begin
                pc_d = redir_target;
            end else if (pend_valid_q) begin
                pc_d = pend_target_q;
            end else begin
                pc_d = pc_q + 32'd4;
            end
            // A stalled illegal fetch is counted once, when it is released.
            if (illegal) begin
                fetch_fault_d = 1'b1;
                if (fault_cnt_q != 8'hFF) begin
                    fault_cnt_d = fault_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
            fetch_fault_q <= 1'b0;
            fault_cnt_q   <= 8'd0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            fetch_fault_q <= fetch_fault_d;
            fault_cnt_q   <= fault_cnt_d;
        end
    end

    assign PC_F        = pc_q;
    assign clear_F     = illegal;
    assign fetch_fault = fetch_fault_q;
    assign fault_cnt   = fault_cnt_q;

endmodule
